// File: rtl/bird_pkg.sv
// Shared encodings for the bird core: opcodes, ALU operations, FSM states.
package bird_pkg;

    // Top-nibble opcodes of an instruction word
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LDI  = 4'h1;
    localparam logic [3:0] OPC_LD   = 4'h2;
    localparam logic [3:0] OPC_ST   = 4'h3;
    localparam logic [3:0] OPC_JZ   = 4'h4;
    localparam logic [3:0] OPC_JMP  = 4'h5;
    localparam logic [3:0] OPC_JC   = 4'h6;
    localparam logic [3:0] OPC_ALU  = 4'h7;
    localparam logic [3:0] OPC_PUSH = 4'h8;
    localparam logic [3:0] OPC_POP  = 4'h9;
    localparam logic [3:0] OPC_CALL = 4'hA;
    localparam logic [3:0] OPC_RET  = 4'hB;
    localparam logic [3:0] OPC_RETI = 4'hE;
    localparam logic [3:0] OPC_EIDI = 4'hF;

    // ALU op field
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_UNARY = 3'd7;

    // Unary sub-operations, selected by the srcA field
    localparam logic [2:0] UN_NOT = 3'd0;
    localparam logic [2:0] UN_MOV = 3'd1;
    localparam logic [2:0] UN_INC = 3'd2;
    localparam logic [2:0] UN_DEC = 3'd3;

    // r7 doubles as the stack pointer
    localparam logic [2:0] SP_IDX = 3'd7;

    typedef enum logic [4:0] {
        S_FETCH = 5'd0,
        S_LDI   = 5'd1,
        S_LD    = 5'd2,
        S_ST    = 5'd3,
        S_JMP   = 5'd4,
        S_ALU   = 5'd5,
        S_PUSH  = 5'd6,
        S_POP1  = 5'd7,
        S_POP2  = 5'd8,
        S_CALL  = 5'd9,
        S_RET1  = 5'd10,
        S_RET2  = 5'd11,
        S_INT   = 5'd12
    } state_t;

    // States that drive a memory write
    function automatic logic is_write_state(input state_t s);
        return (s == S_ST) || (s == S_PUSH) || (s == S_CALL) || (s == S_INT);
    endfunction

endpackage

// File: rtl/bird_alu.sv
// Combinational ALU: binary ops on a/b, unary ops on b, with zero and carry/borrow.
module bird_alu
    import bird_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // Result and carry; arithmetic runs one bit wider so the top bit is carry/borrow
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        unique case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_UNARY: begin
                unique case (sel)
                    UN_NOT: result = {{(DATA_W-1){1'b0}}, (b == '0)};
                    UN_MOV: result = b;
                    UN_INC: begin
                        wide   = {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
                        result = wide[DATA_W-1:0];
                        carry  = wide[DATA_W];
                    end
                    UN_DEC: begin
                        wide   = {1'b0, b} - {{DATA_W{1'b0}}, 1'b1};
                        result = wide[DATA_W-1:0];
                        carry  = wide[DATA_W];
                    end
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/bird_core.sv
// bird CPU core: FSM, register bank and memory bus mux, with DMA hold and one vectored IRQ.
//
// state   | meaning
// FETCH   | instruction boundary: park for hold, take irq, or fetch and decode
// LDI     | load immediate word at pc into dst
// LD      | dst <- mem[srcB]
// ST      | mem[srcB] <- srcA
// JMP     | pc <- pc + offset (JMP, taken JZ/JC)
// ALU     | dst <- alu result, update Z/C
// PUSH    | mem[SP] <- srcA, SP-1
// POP1    | SP+1
// POP2    | dst <- mem[SP]
// CALL    | mem[SP] <- pc, SP-1, pc <- target
// RET1    | SP+1
// RET2    | pc <- mem[SP] (RETI also sets IE)
// INT     | mem[SP] <- pc, SP-1, pc <- IRQ_VEC, IE <- 0
module bird_core
    import bird_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int SP_INIT = 2**ADDR_W - 1,
    parameter int IRQ_VEC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              hold,
    output logic              hold_ack,
    input  logic              irq,
    output logic              irq_ack,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address,
    output logic              memwt
);

    if (DATA_W < 16) begin : g_bad_data_w
        $error("bird_core: DATA_W must be at least 16");
    end
    if (ADDR_W > DATA_W - 4) begin : g_bad_addr_w
        $error("bird_core: ADDR_W must not exceed DATA_W-4");
    end

    state_t             state, state_nx;
    logic               hold_ack_q;
    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  regs [0:7];
    logic [3:0]         opc_q;
    logic [DATA_W-5:0]  ir_q;
    logic               flag_z, flag_c, ie;

    logic [3:0]         opc_in;
    logic [DATA_W-5:0]  ir_in;
    logic [2:0]         f_op, f_a, f_b, f_d;
    logic [DATA_W-1:0]  sp, reg_a, reg_b;
    logic [ADDR_W-1:0]  jmp_target;
    logic               parked, take_irq;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero, alu_carry;

    assign opc_in     = data_in[DATA_W-1:DATA_W-4];
    assign ir_in      = data_in[DATA_W-5:0];
    assign f_op       = ir_q[11:9];
    assign f_a        = ir_q[8:6];
    assign f_b        = ir_q[5:3];
    assign f_d        = ir_q[2:0];
    assign sp         = regs[SP_IDX];
    assign reg_a      = regs[f_a];
    assign reg_b      = regs[f_b];
    // pc already points past the fetched word; the add wraps at ADDR_W
    assign jmp_target = pc + ir_q[ADDR_W-1:0];
    // The bus stays with the blitter until hold_ack has actually dropped
    assign parked     = hold || hold_ack_q;
    assign take_irq   = irq && ie;
    assign hold_ack   = hold_ack_q;

    bird_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (f_op),
        .sel    (f_a),
        .a      (reg_a),
        .b      (reg_b),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    // State register and registered bus grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            hold_ack_q <= 1'b0;
        end else begin
            state      <= state_nx;
            hold_ack_q <= (state == S_FETCH) && hold;
        end
    end

    // Next state and bus outputs
    always_comb begin
        state_nx = state;
        address  = pc;
        data_out = '0;
        irq_ack  = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (parked) begin
                    state_nx = S_FETCH;
                end else if (take_irq) begin
                    state_nx = S_INT;
                end else begin
                    unique case (opc_in)
                        OPC_LDI:            state_nx = S_LDI;
                        OPC_LD:             state_nx = S_LD;
                        OPC_ST:             state_nx = S_ST;
                        OPC_JZ:             state_nx = flag_z ? S_JMP : S_FETCH;
                        OPC_JMP:            state_nx = S_JMP;
                        OPC_JC:             state_nx = flag_c ? S_JMP : S_FETCH;
                        OPC_ALU:            state_nx = S_ALU;
                        OPC_PUSH:           state_nx = S_PUSH;
                        OPC_POP:            state_nx = S_POP1;
                        OPC_CALL:           state_nx = S_CALL;
                        OPC_RET, OPC_RETI:  state_nx = S_RET1;
                        default:            state_nx = S_FETCH;
                    endcase
                end
            end
            S_LD: begin
                address  = reg_b[ADDR_W-1:0];
                state_nx = S_FETCH;
            end
            S_ST: begin
                address  = reg_b[ADDR_W-1:0];
                data_out = reg_a;
                state_nx = S_FETCH;
            end
            S_PUSH: begin
                address  = sp[ADDR_W-1:0];
                data_out = reg_a;
                state_nx = S_FETCH;
            end
            S_POP1:  state_nx = S_POP2;
            S_POP2: begin
                address  = sp[ADDR_W-1:0];
                state_nx = S_FETCH;
            end
            S_CALL: begin
                address  = sp[ADDR_W-1:0];
                data_out = {{(DATA_W-ADDR_W){1'b0}}, pc};
                state_nx = S_FETCH;
            end
            S_RET1:  state_nx = S_RET2;
            S_RET2: begin
                address  = sp[ADDR_W-1:0];
                state_nx = S_FETCH;
            end
            S_INT: begin
                address  = sp[ADDR_W-1:0];
                data_out = {{(DATA_W-ADDR_W){1'b0}}, pc};
                irq_ack  = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    assign memwt = is_write_state(state) && !hold_ack_q;

    // Datapath: pc, register bank, flags, interrupt enable, latched instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            opc_q  <= OPC_NOP;
            ir_q   <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            ie     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (i == int'(SP_IDX)) ? DATA_W'(SP_INIT) : '0;
            end
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (!parked && !take_irq) begin
                        pc    <= pc + 1'b1;
                        opc_q <= opc_in;
                        ir_q  <= ir_in;
                        if (opc_in == OPC_EIDI) begin
                            ie <= ir_in[0];
                        end
                    end
                end
                S_LDI: begin
                    regs[f_d] <= data_in;
                    pc        <= pc + 1'b1;
                end
                S_LD:   regs[f_d] <= data_in;
                S_JMP:  pc <= jmp_target;
                S_ALU: begin
                    regs[f_d] <= alu_result;
                    flag_z    <= alu_zero;
                    flag_c    <= alu_carry;
                end
                S_PUSH: regs[SP_IDX] <= sp - 1'b1;
                S_POP1: regs[SP_IDX] <= sp + 1'b1;
                S_POP2: regs[f_d] <= data_in;
                S_CALL: begin
                    regs[SP_IDX] <= sp - 1'b1;
                    pc           <= jmp_target;
                end
                S_RET1: regs[SP_IDX] <= sp + 1'b1;
                S_RET2: begin
                    pc <= data_in[ADDR_W-1:0];
                    if (opc_q == OPC_RETI) begin
                        ie <= 1'b1;
                    end
                end
                S_INT: begin
                    regs[SP_IDX] <= sp - 1'b1;
                    pc           <= ADDR_W'(IRQ_VEC);
                    ie           <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
